// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift register.
// A word is accepted through a valid/ready handshake and shifted out one bit
// per clock with en=1. A registered one-cycle done pulse marks each finished word.
// Words can follow each other with no gap when the producer holds load_valid.
// The default build is MSB-first only.
// Define PISO_DIR_SEL_EN to add the dir input:
//   dir = 1 shifts MSB-first, dir = 0 shifts LSB-first.
//   dir is latched per word when the word is accepted.

module piso_serializer #(
  parameter int unsigned MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] din,
  input  logic           en,
`ifdef PISO_DIR_SEL_EN
  input  logic           dir,
`endif
  output logic           dout,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = $clog2(MSB);
  localparam logic [CW-1:0] CntLast = CW'(MSB - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e         state_q;
  logic [MSB-1:0] shreg_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic           last_bit;
  logic           accept;

`ifdef PISO_DIR_SEL_EN
  logic           dir_q;
`endif

  // Last bit of the current word is on dout and will be consumed on this edge.
  assign last_bit = (state_q == StShift) && en && (cnt_q == CntLast);

  // Ready does not look at load_valid, so there is no valid->ready loop.
  assign load_ready = (state_q == StIdle) || last_bit;
  assign accept     = load_valid && load_ready;

  assign busy = (state_q == StShift);
  assign done = done_q;

  // Serial output: always 0 when idle, else the current head bit of the word.
  always_comb begin
    dout = 1'b0;
    if (state_q == StShift) begin
`ifdef PISO_DIR_SEL_EN
      dout = dir_q ? shreg_q[MSB-1] : shreg_q[0];
`else
      dout = shreg_q[MSB-1];
`endif
    end
  end

  // Control FSM and datapath: load, enabled shift, completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_DIR_SEL_EN
      dir_q   <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q <= din;
            cnt_q   <= '0;
`ifdef PISO_DIR_SEL_EN
            dir_q   <= dir;
`endif
            state_q <= StShift;
          end
        end
        StShift: begin
          if (en) begin
            if (cnt_q == CntLast) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
              if (load_valid) begin
                // Back-to-back reload: next word's first bit follows with no gap.
                shreg_q <= din;
`ifdef PISO_DIR_SEL_EN
                dir_q   <= dir;
`endif
              end else begin
                shreg_q <= '0;
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
`ifdef PISO_DIR_SEL_EN
              if (dir_q) begin
                shreg_q <= {shreg_q[MSB-2:0], 1'b0};
              end else begin
                shreg_q <= {1'b0, shreg_q[MSB-1:1]};
              end
`else
              shreg_q <= {shreg_q[MSB-2:0], 1'b0};
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (MSB = 4).
// Inputs change on the falling edge.
// Outputs are compared 1 time unit later, before the next rising edge.
// Each table row therefore describes one clock cycle:
//   - the inputs driven during that cycle, and
//   - the outputs expected during that cycle.

module tb_piso_serializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] din;
  logic         en;
  logic         dout;
  logic         busy;
  logic         done;
`ifdef PISO_DIR_SEL_EN
  logic         dir;
`endif

  int applied = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .MSB(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .en         (en),
`ifdef PISO_DIR_SEL_EN
    .dir        (dir),
`endif
    .dout       (dout),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic         lv;
    logic [W-1:0] din;
    logic         en;
    logic         dout;
    logic         busy;
    logic         done;
    logic         ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic lv, input logic [W-1:0] d, input logic e,
                              input logic x_dout, input logic x_busy, input logic x_done,
                              input logic x_ready);
    vec_t v;
    v.lv = lv; v.din = d; v.en = e;
    v.dout = x_dout; v.busy = x_busy; v.done = x_done; v.ready = x_ready;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    applied++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] d, input logic e);
    @(negedge clk);
    load_valid = lv;
    din        = d;
    en         = e;
    #1;
  endtask

  task automatic check_all(input string tag, input logic x_dout, input logic x_busy,
                           input logic x_done, input logic x_ready);
    check({tag, " dout"},       dout,       x_dout);
    check({tag, " busy"},       busy,       x_busy);
    check({tag, " done"},       done,       x_done);
    check({tag, " load_ready"}, load_ready, x_ready);
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    en         = 1'b0;
`ifdef PISO_DIR_SEL_EN
    dir        = 1'b1;
`endif

    // Table columns:
    //   inputs:  load_valid, din, en
    //   outputs: dout, busy, done, load_ready
    // Word 1011 with en held high.
    add(1, 4'b1011, 1, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 1);
    // Word 1011 with en pattern 1,0,0,1,1,1; en=0 during the accepting cycle.
    add(1, 4'b1011, 0, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 0, 0, 0, 1);
    // Back-to-back words: 1100, then 0011 offered on the last bit.
    add(1, 4'b1100, 1, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(1, 4'b0011, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 1, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1, 1);
    // Load attempt mid-word with 1111 is ignored.
    add(1, 4'b1011, 1, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 0, 0);
    add(1, 4'b1111, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 0, 0, 0, 1);

    // State while reset is held.
    #3;
    check_all("reset", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].din, vecs[i].en);
      check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].busy, vecs[i].done,
                vecs[i].ready);
    end

    // Asynchronous reset after two bits of 1011 have been shifted out.
    drive(1, 4'b1011, 1);
    drive(0, 4'b0000, 1);
    check("mid dout bit0", dout, 1'b1);
    drive(0, 4'b0000, 1);
    check("mid dout bit1", dout, 1'b0);
    drive(0, 4'b0000, 0);
    check_all("pre-reset", 1, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'b0000, 1);
      check_all($sformatf("post-reset%0d", k), 0, 0, 0, 1);
    end

`ifdef PISO_DIR_SEL_EN
    // LSB-first 1011 gives 1,1,0,1; dir toggles mid-word and must be ignored.
    dir = 1'b0;
    drive(1, 4'b1011, 1);
    check("dir load ready", load_ready, 1'b1);
    drive(0, 4'b0000, 1);
    check("lsb dout0", dout, 1'b1);
    dir = 1'b1;
    drive(0, 4'b0000, 1);
    check("lsb dout1", dout, 1'b1);
    dir = 1'b0;
    drive(0, 4'b0000, 1);
    check("lsb dout2", dout, 1'b0);
    dir = 1'b1;
    drive(0, 4'b0000, 1);
    check("lsb dout3", dout, 1'b1);
    drive(0, 4'b0000, 1);
    check("lsb done", done, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end

endmodule
